// File: rtl/sata_dma_stream_demux_pkt_pkg.sv
// Shared types and helpers for the packet-aware DMA stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sata_dma_pkg;

    // Select width for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packet lock state: IDLE waits for a first beat, BUSY holds the destination.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lock_state_t;

endpackage

// File: rtl/sata_dma_stream_demux_pkt_if.sv
// Stream bundle between the DMA transport engine and the per-channel consumers.
// Latency: n/a (wires only).
// Backpressure: i_rdy toward the source, o_rdy per output channel.
interface sata_dma_stream_demux_pkt_if
    import sata_dma_pkg::*;
#(
    parameter int OUTPUTS = 2,
    parameter int WIDTH   = 8
);
    localparam int SELW = sel_width(OUTPUTS);

    logic [SELW-1:0]               select;
    logic [WIDTH-1:0]              i_dat;
    logic                          i_eop;
    logic                          i_val;
    logic                          i_rdy;
    logic [OUTPUTS-1:0][WIDTH-1:0] o_dat;
    logic [OUTPUTS-1:0]            o_eop;
    logic [OUTPUTS-1:0]            o_val;
    logic [OUTPUTS-1:0]            o_rdy;

    modport master (
        output select, i_dat, i_eop, i_val, o_rdy,
        input  i_rdy, o_dat, o_eop, o_val
    );

    modport slave (
        input  select, i_dat, i_eop, i_val, o_rdy,
        output i_rdy, o_dat, o_eop, o_val
    );
endinterface

// File: rtl/sata_dma_stream_skid.sv
// Generic two-entry valid/ready skid buffer with registered outputs and registered up_rdy.
// Latency: 1 cycle from accept to dn_vld when the main entry is empty; 1 beat/cycle sustained.
// Backpressure: up_rdy drops the cycle after the skid entry fills; it rises again once it drains.
module sata_dma_stream_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] up_dat,
    input  logic         up_vld,
    output logic         up_rdy,
    output logic [W-1:0] dn_dat,
    output logic         dn_vld,
    input  logic         dn_rdy
);
    logic [W-1:0] m_dat;
    logic [W-1:0] s_dat;
    logic         m_vld;
    logic         s_vld;
    logic         rdy_q;
    logic         push;
    logic         m_free;

    // rdy_q mirrors !s_vld, so a push always finds the skid entry empty.
    assign push   = up_vld & rdy_q;
    assign m_free = ~m_vld | dn_rdy;

    // Main/skid entry update; the skid entry always drains into main before new beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_dat <= '0;
            s_dat <= '0;
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            rdy_q <= 1'b0;
        end else if (m_free) begin
            if (s_vld) begin
                m_dat <= s_dat;
                m_vld <= 1'b1;
                s_vld <= 1'b0;
            end else begin
                m_vld <= push;
                if (push) begin
                    m_dat <= up_dat;
                end
            end
            rdy_q <= 1'b1;
        end else if (push) begin
            s_dat <= up_dat;
            s_vld <= 1'b1;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= ~s_vld;
        end
    end

    assign up_rdy = rdy_q;
    assign dn_dat = m_dat;
    assign dn_vld = m_vld;
endmodule

// File: rtl/sata_dma_stream_demux_pkt.sv
// Packet-locked 1:OUTPUTS stream demux; destination sampled on first beat, optional per-output
// packet counters under SATA_DMA_STREAM_DEMUX_PKT_CNT_EN. Latency: 1 cycle accept to o_val.
// Backpressure: only o_rdy of the current destination stalls; i_rdy is registered via the skid.
module sata_dma_stream_demux_pkt
    import sata_dma_pkg::*;
#(
    parameter int OUTPUTS = 2,
    parameter int WIDTH   = 8,
    parameter int CNTW    = 16
) (
    input  logic clk,
    input  logic reset,
    sata_dma_stream_demux_pkt_if.slave bus
`ifdef SATA_DMA_STREAM_DEMUX_PKT_CNT_EN
    ,
    output logic [OUTPUTS-1:0][CNTW-1:0] o_pkt_cnt
`endif
);
    localparam int SELW = sel_width(OUTPUTS);
    localparam int PAYW = SELW + 1 + WIDTH;
    localparam logic [0:0] LK_IDLE = 1'(ST_IDLE);
    localparam logic [0:0] LK_BUSY = 1'(ST_BUSY);

    // View of the main (output) skid entry.
    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             eop;
        logic [SELW-1:0]  dst;
        logic             val;
    } entry_t;

    if (OUTPUTS < 1 || CNTW < 1) begin : g_bad_param
        $error("sata_dma_stream_demux_pkt: OUTPUTS and CNTW must be >= 1");
    end

    logic [0:0]         lock_q;
    logic [SELW-1:0]    held_q;
    logic [SELW-1:0]    dst_sel;
    logic               in_range;
    logic               accept;
    logic               up_rdy;
    logic               m_vld;
    logic               dn_rdy;
    logic [PAYW-1:0]    up_pay;
    logic [PAYW-1:0]    dn_pay;
    logic [OUTPUTS-1:0] val_vec;
    entry_t             m;

    // Destination: live select on a first beat, held value inside a packet.
    always_comb begin
        dst_sel = (lock_q == LK_BUSY) ? held_q : bus.select;
        if (OUTPUTS == 1) begin
            dst_sel = '0;
        end
    end

    // Out-of-range beats are accepted but never pushed into the skid stage.
    assign in_range  = (32'(dst_sel) < 32'(OUTPUTS));
    assign accept    = bus.i_val & up_rdy;
    assign up_pay    = {dst_sel, bus.i_eop, bus.i_dat};
    assign bus.i_rdy = up_rdy;

    // Lock FSM: a non-final first beat locks the destination until the eop beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= LK_IDLE;
            held_q <= '0;
        end else if (accept) begin
            if (bus.i_eop) begin
                lock_q <= LK_IDLE;
            end else if (lock_q == LK_IDLE) begin
                lock_q <= LK_BUSY;
                held_q <= dst_sel;
            end
        end
    end

    sata_dma_stream_skid #(.W(PAYW)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .up_dat (up_pay),
        .up_vld (bus.i_val & in_range),
        .up_rdy (up_rdy),
        .dn_dat (dn_pay),
        .dn_vld (m_vld),
        .dn_rdy (dn_rdy)
    );

    assign m.dat = dn_pay[WIDTH-1:0];
    assign m.eop = dn_pay[WIDTH];
    assign m.dst = dn_pay[PAYW-1:WIDTH+1];
    assign m.val = m_vld;

    // Main entry advances only when its own destination takes the beat.
    assign dn_rdy = |(val_vec & bus.o_rdy);

    for (genvar k = 0; k < OUTPUTS; k++) begin : g_out
        assign val_vec[k]   = m.val && (m.dst == SELW'(k));
        assign bus.o_val[k] = val_vec[k];
        assign bus.o_eop[k] = val_vec[k] & m.eop;
        assign bus.o_dat[k] = m.dat;
    end

`ifdef SATA_DMA_STREAM_DEMUX_PKT_CNT_EN
    logic [OUTPUTS-1:0][CNTW-1:0] cnt_q;

    // Count packets completed on each output; wraps naturally at 2^CNTW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < OUTPUTS; k++) begin
                if (val_vec[k] & bus.o_rdy[k] & m.eop) begin
                    cnt_q[k] <= cnt_q[k] + CNTW'(1);
                end
            end
        end
    end

    assign o_pkt_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_sata_dma_stream_demux_pkt.sv
// Directed self-checking bench for sata_dma_stream_demux_pkt (4-output and 3-output instances).
// Latency: checks sample 1 time unit after each rising clock edge.
// Backpressure: exercised by stalling o_rdy[0] on the 4-output instance.
module tb_sata_dma_stream_demux_pkt;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    sata_dma_stream_demux_pkt_if #(.OUTPUTS(4), .WIDTH(8)) bus4 ();
    sata_dma_stream_demux_pkt_if #(.OUTPUTS(3), .WIDTH(8)) bus3 ();

`ifdef SATA_DMA_STREAM_DEMUX_PKT_CNT_EN
    logic [3:0][1:0] cnt4;
    logic [2:0][1:0] cnt3;
`endif

    sata_dma_stream_demux_pkt #(.OUTPUTS(4), .WIDTH(8), .CNTW(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
`ifdef SATA_DMA_STREAM_DEMUX_PKT_CNT_EN
        ,
        .o_pkt_cnt (cnt4)
`endif
    );

    sata_dma_stream_demux_pkt #(.OUTPUTS(3), .WIDTH(8), .CNTW(2)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
`ifdef SATA_DMA_STREAM_DEMUX_PKT_CNT_EN
        ,
        .o_pkt_cnt (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [1:0] sel, input logic [7:0] d, input logic e);
        bus4.i_val  = 1'b1;
        bus4.select = sel;
        bus4.i_dat  = d;
        bus4.i_eop  = e;
    endtask

    task automatic idle4();
        bus4.i_val = 1'b0;
        bus4.i_eop = 1'b0;
    endtask

    task automatic drive3(input logic [1:0] sel, input logic [7:0] d, input logic e);
        bus3.i_val  = 1'b1;
        bus3.select = sel;
        bus3.i_dat  = d;
        bus3.i_eop  = e;
    endtask

    task automatic idle3();
        bus3.i_val = 1'b0;
        bus3.i_eop = 1'b0;
    endtask

    // Compare the 4-output instance against one expected output word.
    task automatic expect4(input string tag, input int idx, input logic [3:0] val,
                           input logic [7:0] d, input logic [3:0] eop);
        check_eq({tag, "_val"}, 32'(bus4.o_val), 32'(val));
        check_eq({tag, "_dat"}, 32'(bus4.o_dat[idx]), 32'(d));
        check_eq({tag, "_eop"}, 32'(bus4.o_eop), 32'(eop));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus4.i_val  = 1'b0;
        bus4.i_eop  = 1'b0;
        bus4.i_dat  = '0;
        bus4.select = '0;
        bus4.o_rdy  = 4'hF;
        bus3.i_val  = 1'b0;
        bus3.i_eop  = 1'b0;
        bus3.i_dat  = '0;
        bus3.select = '0;
        bus3.o_rdy  = 3'h7;

        // Reset state
        repeat (3) tick();
        expect4("rst", 0, 4'b0000, 8'h00, 4'b0000);
        check_eq("rst_irdy", 32'(bus4.i_rdy), 32'd0);
        check_eq("rst_irdy3", 32'(bus3.i_rdy), 32'd0);
        reset = 1'b1;
        tick();
        check_eq("rel_irdy", 32'(bus4.i_rdy), 32'd1);
        check_eq("rel_irdy3", 32'(bus3.i_rdy), 32'd1);

        // Basic routing and one-cycle latency
        check_eq("rt_pre_val", 32'(bus4.o_val), 32'd0);
        drive4(2'd2, 8'h11, 1'b0); tick();
        expect4("rt0", 2, 4'b0100, 8'h11, 4'b0000);
        drive4(2'd2, 8'h22, 1'b0); tick();
        expect4("rt1", 2, 4'b0100, 8'h22, 4'b0000);
        drive4(2'd2, 8'h33, 1'b1); tick();
        expect4("rt2", 2, 4'b0100, 8'h33, 4'b0100);
        idle4(); tick();
        check_eq("rt_done_val", 32'(bus4.o_val), 32'd0);

        // Select change inside a packet is ignored
        drive4(2'd2, 8'hA1, 1'b0); tick();
        expect4("sc0", 2, 4'b0100, 8'hA1, 4'b0000);
        drive4(2'd1, 8'hA2, 1'b0); tick();
        expect4("sc1", 2, 4'b0100, 8'hA2, 4'b0000);
        drive4(2'd1, 8'hA3, 1'b0); tick();
        expect4("sc2", 2, 4'b0100, 8'hA3, 4'b0000);
        drive4(2'd1, 8'hA4, 1'b1); tick();
        expect4("sc3", 2, 4'b0100, 8'hA4, 4'b0100);
        drive4(2'd1, 8'hB1, 1'b1); tick();
        expect4("sc_next", 1, 4'b0010, 8'hB1, 4'b0010);
        idle4(); tick();
        check_eq("sc_done_val", 32'(bus4.o_val), 32'd0);

        // Back-pressure on output 0; o_rdy[1] toggling must not matter
        bus4.o_rdy = 4'b1110;
        drive4(2'd0, 8'hC0, 1'b0); tick();
        expect4("bp0", 0, 4'b0001, 8'hC0, 4'b0000);
        check_eq("bp0_irdy", 32'(bus4.i_rdy), 32'd1);
        drive4(2'd0, 8'hC1, 1'b0); tick();
        expect4("bp1", 0, 4'b0001, 8'hC0, 4'b0000);
        check_eq("bp1_irdy", 32'(bus4.i_rdy), 32'd0);
        drive4(2'd0, 8'hC2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus4.o_rdy[1] = ~bus4.o_rdy[1];
            tick();
            expect4("bp_hold", 0, 4'b0001, 8'hC0, 4'b0000);
            check_eq("bp_hold_irdy", 32'(bus4.i_rdy), 32'd0);
        end
        bus4.o_rdy = 4'hF;
        tick();
        expect4("bp_rel1", 0, 4'b0001, 8'hC1, 4'b0000);
        check_eq("bp_rel1_irdy", 32'(bus4.i_rdy), 32'd1);
        tick();
        expect4("bp_rel2", 0, 4'b0001, 8'hC2, 4'b0000);
        drive4(2'd0, 8'hC3, 1'b1); tick();
        expect4("bp_rel3", 0, 4'b0001, 8'hC3, 4'b0001);
        idle4(); tick();
        check_eq("bp_done_val", 32'(bus4.o_val), 32'd0);

        // Out-of-range destination is swallowed; next packet intact
        drive3(2'd3, 8'hF0, 1'b0); tick();
        check_eq("drop0_irdy", 32'(bus3.i_rdy), 32'd1);
        check_eq("drop0_val", 32'(bus3.o_val), 32'd0);
        drive3(2'd3, 8'hF1, 1'b1); tick();
        check_eq("drop1_irdy", 32'(bus3.i_rdy), 32'd1);
        check_eq("drop1_val", 32'(bus3.o_val), 32'd0);
        drive3(2'd0, 8'h60, 1'b0); tick();
        check_eq("after0_val", 32'(bus3.o_val), 32'b001);
        check_eq("after0_dat", 32'(bus3.o_dat[0]), 32'h60);
        check_eq("after0_eop", 32'(bus3.o_eop), 32'd0);
        drive3(2'd2, 8'h61, 1'b1); tick();
        check_eq("after1_val", 32'(bus3.o_val), 32'b001);
        check_eq("after1_dat", 32'(bus3.o_dat[0]), 32'h61);
        check_eq("after1_eop", 32'(bus3.o_eop), 32'b001);
        idle3(); tick();
        check_eq("drop_done_val", 32'(bus3.o_val), 32'd0);

        // Reset in the middle of a packet
        drive4(2'd3, 8'hD0, 1'b0); tick();
        expect4("mr0", 3, 4'b1000, 8'hD0, 4'b0000);
        drive4(2'd3, 8'hD1, 1'b0); tick();
        expect4("mr1", 3, 4'b1000, 8'hD1, 4'b0000);
        drive4(2'd3, 8'hD2, 1'b0);
        reset = 1'b0;
        #1;
        expect4("mr_async", 3, 4'b0000, 8'h00, 4'b0000);
        check_eq("mr_async_irdy", 32'(bus4.i_rdy), 32'd0);
        tick();
        check_eq("mr_hold_irdy", 32'(bus4.i_rdy), 32'd0);
        idle4();
        reset = 1'b1;
        tick();
        check_eq("mr_rel_irdy", 32'(bus4.i_rdy), 32'd1);
        drive4(2'd1, 8'hE0, 1'b1); tick();
        expect4("mr_new", 1, 4'b0010, 8'hE0, 4'b0010);
        idle4(); tick();
        check_eq("mr_done_val", 32'(bus4.o_val), 32'd0);

`ifdef SATA_DMA_STREAM_DEMUX_PKT_CNT_EN
        // Packet counters, CNTW = 2 so five packets wrap to one
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_eq("cnt_rst1", 32'(cnt4[1]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive4(2'd1, 8'(8'h50 + i), 1'b1);
            tick();
        end
        idle4(); tick();
        check_eq("cnt_out1", 32'(cnt4[1]), 32'd1);
        check_eq("cnt_out0", 32'(cnt4[0]), 32'd0);
        check_eq("cnt_out2", 32'(cnt4[2]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
